// File: rtl/doubler_frame_arbiter.sv
// rtl/doubler_frame_arbiter.sv - frame-granular two-source arbiter feeding one bus_doubler
//
// Shares a single downstream bus_doubler between two video sources. Ownership
// only changes on a start-of-frame (vsync rising edge) of the relevant source,
// so the doubler never receives a torn frame. Output is blanked while waiting.
//
// Ports:
//   in_clk, rst                 clock, asynchronous active-high reset
//   s0_req, s1_req              level-sensitive ownership requests
//   s0_* / s1_*                 source video (hsync, vsync, den, data)
//   out_*                       registered video toward bus_doubler in_*
//   gnt                         one-hot owner while streaming, 00 otherwise
//   frames_fwd                  count of forwarded frames, wraps at 16 bits

module doubler_frame_arbiter #(
    parameter int INPUT_WIDTH = 8,
    parameter int FRAME_QUOTA = 2
) (
    input  logic                   in_clk,
    input  logic                   rst,
    input  logic                   s0_req,
    input  logic                   s1_req,
    input  logic                   s0_hsync,
    input  logic                   s0_vsync,
    input  logic                   s0_den,
    input  logic [INPUT_WIDTH-1:0] s0_data,
    input  logic                   s1_hsync,
    input  logic                   s1_vsync,
    input  logic                   s1_den,
    input  logic [INPUT_WIDTH-1:0] s1_data,
    output logic                   out_hsync,
    output logic                   out_vsync,
    output logic                   out_den,
    output logic [INPUT_WIDTH-1:0] out_data,
    output logic [1:0]             gnt,
    output logic [15:0]            frames_fwd
);

    localparam logic [7:0] QUOTA = 8'(FRAME_QUOTA);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        STREAM   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    // sel_q is the candidate in WAIT_SOF and the owner in STREAM
    logic                   sel_q, sel_d;
    logic                   rr_q, rr_d;
    logic [7:0]             quota_q, quota_d;
    logic [15:0]            frames_q, frames_d;
    logic [1:0]             gnt_q, gnt_d;
    logic                   vs0_q, vs1_q;
    logic                   hs_q, vs_q, den_q;
    logic                   hs_d, vs_d, den_d;
    logic [INPUT_WIDTH-1:0] data_q, data_d;

    logic sof0, sof1;
    logic sof_sel, req_sel, req_oth, req_rr;
    logic fwd;

    assign sof0    = s0_vsync & ~vs0_q;
    assign sof1    = s1_vsync & ~vs1_q;
    // Only the selected source's SOF is ever evaluated; the other is ignored
    assign sof_sel = sel_q ? sof1 : sof0;
    assign req_sel = sel_q ? s1_req : s0_req;
    assign req_oth = sel_q ? s0_req : s1_req;
    assign req_rr  = rr_q  ? s1_req : s0_req;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_d     = rr_q;
        quota_d  = quota_q;
        frames_d = frames_q;
        gnt_d    = gnt_q;
        fwd      = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = 2'b00;
                if (s0_req || s1_req) begin
                    sel_d   = req_rr ? rr_q : ~rr_q;
                    state_d = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                gnt_d = 2'b00;
                if (!req_sel) begin
                    state_d = IDLE;
                end else if (sof_sel) begin
                    state_d  = STREAM;
                    rr_d     = ~sel_q;
                    quota_d  = 8'd1;
                    frames_d = frames_q + 16'd1;
                    gnt_d    = sel_q ? 2'b10 : 2'b01;
                    fwd      = 1'b1;
                end
            end
            STREAM: begin
                fwd = 1'b1;
                if (sof_sel) begin
                    if (!req_sel) begin
                        fwd   = 1'b0;
                        gnt_d = 2'b00;
                        if (req_oth) begin
                            sel_d   = ~sel_q;
                            state_d = WAIT_SOF;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (quota_q == QUOTA && req_oth) begin
                        fwd     = 1'b0;
                        gnt_d   = 2'b00;
                        sel_d   = ~sel_q;
                        state_d = WAIT_SOF;
                    end else begin
                        // Saturate so a lone requester never times out
                        quota_d  = (quota_q == QUOTA) ? quota_q : quota_q + 8'd1;
                        frames_d = frames_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_comb begin
        hs_d   = 1'b0;
        vs_d   = 1'b0;
        den_d  = 1'b0;
        data_d = '0;
        if (fwd) begin
            hs_d   = sel_q ? s1_hsync : s0_hsync;
            vs_d   = sel_q ? s1_vsync : s0_vsync;
            den_d  = sel_q ? s1_den   : s0_den;
            data_d = sel_q ? s1_data  : s0_data;
        end
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            rr_q     <= 1'b0;
            quota_q  <= 8'd0;
            frames_q <= 16'd0;
            gnt_q    <= 2'b00;
            vs0_q    <= 1'b0;
            vs1_q    <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            den_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_q     <= rr_d;
            quota_q  <= quota_d;
            frames_q <= frames_d;
            gnt_q    <= gnt_d;
            vs0_q    <= s0_vsync;
            vs1_q    <= s1_vsync;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            den_q    <= den_d;
            data_q   <= data_d;
        end
    end

    assign out_hsync  = hs_q;
    assign out_vsync  = vs_q;
    assign out_den    = den_q;
    assign out_data   = data_q;
    assign gnt        = gnt_q;
    assign frames_fwd = frames_q;

endmodule

// File: tb/tb_doubler_frame_arbiter.sv
// tb/tb_doubler_frame_arbiter.sv - directed self-checking bench for doubler_frame_arbiter

module tb_doubler_frame_arbiter;

    logic        in_clk = 1'b0;
    logic        rst = 1'b1;
    logic        s0_req = 1'b0, s1_req = 1'b0;
    logic        s0_hsync = 1'b0, s0_vsync = 1'b0, s0_den = 1'b0;
    logic [7:0]  s0_data = 8'h00;
    logic        s1_hsync = 1'b0, s1_vsync = 1'b0, s1_den = 1'b0;
    logic [7:0]  s1_data = 8'h00;
    logic        out_hsync, out_vsync, out_den;
    logic [7:0]  out_data;
    logic [1:0]  gnt;
    logic [15:0] frames_fwd;

    int checks = 0;
    int errors = 0;

    doubler_frame_arbiter #(.INPUT_WIDTH(8), .FRAME_QUOTA(2)) dut (
        .in_clk(in_clk), .rst(rst),
        .s0_req(s0_req), .s1_req(s1_req),
        .s0_hsync(s0_hsync), .s0_vsync(s0_vsync), .s0_den(s0_den), .s0_data(s0_data),
        .s1_hsync(s1_hsync), .s1_vsync(s1_vsync), .s1_den(s1_den), .s1_data(s1_data),
        .out_hsync(out_hsync), .out_vsync(out_vsync), .out_den(out_den), .out_data(out_data),
        .gnt(gnt), .frames_fwd(frames_fwd)
    );

    always #5 in_clk = ~in_clk;

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic blank_chk(input string tag);
        chk(tag, {out_hsync, out_vsync, out_den, out_data, gnt}, 32'd0);
    endtask

    // One 4-cycle frame driven on both sources in lockstep:
    // SOF, two active pixels, one idle. exp_gnt names the expected owner.
    task automatic frame_both(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [1:0] exp_gnt, input logic [15:0] exp_frames);
        logic [7:0] exp_d;
        exp_d = (exp_gnt == 2'b01) ? d0 : (exp_gnt == 2'b10) ? d1 : 8'h00;
        s0_vsync = 1'b1; s1_vsync = 1'b1;
        tick();
        chk({tag, "_gnt"}, gnt, exp_gnt);
        chk({tag, "_vs"}, out_vsync, exp_gnt != 2'b00);
        s0_vsync = 1'b0; s1_vsync = 1'b0;
        s0_den = 1'b1; s1_den = 1'b1; s0_data = d0; s1_data = d1;
        tick();
        chk({tag, "_data"}, {out_den, out_data}, {exp_gnt != 2'b00, exp_d});
        s0_data = d0 + 8'd1; s1_data = d1 + 8'd1;
        tick();
        s0_den = 1'b0; s1_den = 1'b0; s0_data = 8'h00; s1_data = 8'h00;
        tick();
        chk({tag, "_frames"}, frames_fwd, exp_frames);
    endtask

    initial begin
        // Reset held while sources toggle
        for (int i = 0; i < 6; i++) begin
            s0_vsync = i[0]; s1_vsync = ~i[0]; s0_den = i[1]; s1_den = 1'b1;
            s0_data = 8'(i * 17); s1_data = 8'hFF; s0_req = i[0]; s1_req = 1'b1;
            tick();
        end
        blank_chk("rst_out");
        chk("rst_frames", frames_fwd, 16'd0);
        s0_req = 1'b0; s1_req = 1'b0;
        s0_vsync = 1'b0; s1_vsync = 1'b0; s0_den = 1'b0; s1_den = 1'b0;
        s0_data = 8'h00; s1_data = 8'h00;
        rst = 1'b0;

        // No requests: stays blank while sources run
        for (int i = 0; i < 6; i++) begin
            s0_vsync = i[1]; s1_vsync = i[0]; s0_den = 1'b1; s0_data = 8'h3C;
            tick();
        end
        blank_chk("noreq_out");
        chk("noreq_frames", frames_fwd, 16'd0);
        s0_vsync = 1'b0; s1_vsync = 1'b0; s0_den = 1'b0; s0_data = 8'h00;
        tick();

        // Single source s0
        s0_req = 1'b1;
        tick();
        blank_chk("single_wait");
        s0_vsync = 1'b1;
        tick();
        chk("single_vs", out_vsync, 1'b1);
        chk("single_gnt", gnt, 2'b01);
        chk("single_frames", frames_fwd, 16'd1);
        s0_vsync = 1'b0; s0_den = 1'b1; s0_data = 8'hA1;
        tick();
        chk("single_d0", {out_den, out_data}, {1'b1, 8'hA1});
        s0_data = 8'h53; s0_hsync = 1'b1;
        tick();
        chk("single_d1", {out_hsync, out_den, out_data}, {1'b1, 1'b1, 8'h53});
        s0_den = 1'b0; s0_data = 8'h00; s0_hsync = 1'b0;
        tick();

        // Second s0 frame, req drops mid-frame
        s0_vsync = 1'b1;
        tick();
        chk("drop_frames", frames_fwd, 16'd2);
        s0_vsync = 1'b0; s0_den = 1'b1; s0_data = 8'h77; s0_req = 1'b0;
        tick();
        chk("drop_cont", {gnt, out_den, out_data}, {2'b01, 1'b1, 8'h77});
        s0_data = 8'h78;
        tick();
        chk("drop_cont2", {out_den, out_data}, {1'b1, 8'h78});
        s0_den = 1'b0; s0_data = 8'h00;
        tick();
        s0_vsync = 1'b1;
        tick();
        blank_chk("drop_blank");
        chk("drop_frames2", frames_fwd, 16'd2);
        s0_vsync = 1'b0;
        tick();

        // Candidate s1 withdraws before its SOF
        s1_req = 1'b1;
        tick();
        s1_req = 1'b0;
        tick();
        s1_vsync = 1'b1; s1_den = 1'b1; s1_data = 8'h99;
        tick();
        s1_vsync = 1'b0;
        tick();
        blank_chk("cand_out");
        chk("cand_frames", frames_fwd, 16'd2);
        s1_den = 1'b0; s1_data = 8'h00;

        // Fairness from reset with both requesting
        rst = 1'b1;
        tick();
        chk("fair_rst_frames", frames_fwd, 16'd0);
        rst = 1'b0;
        s0_req = 1'b1; s1_req = 1'b1;
        tick();
        frame_both("f1", 8'h10, 8'h20, 2'b01, 16'd1);
        frame_both("f2", 8'h11, 8'h21, 2'b01, 16'd2);
        frame_both("f3", 8'h12, 8'h22, 2'b00, 16'd2);
        frame_both("f4", 8'h13, 8'h23, 2'b10, 16'd3);
        frame_both("f5", 8'h14, 8'h24, 2'b10, 16'd4);
        frame_both("f6", 8'h15, 8'h25, 2'b00, 16'd4);
        frame_both("f7", 8'h16, 8'h26, 2'b01, 16'd5);

        // Reset mid-stream
        s0_vsync = 1'b1; s1_vsync = 1'b1;
        tick();
        s0_vsync = 1'b0; s1_vsync = 1'b0;
        s0_den = 1'b1; s0_data = 8'hE7;
        tick();
        chk("mid_fwd", {out_den, out_data, frames_fwd}, {1'b1, 8'hE7, 16'd6});
        #2;
        rst = 1'b1;
        #1;
        blank_chk("mid_async");
        chk("mid_frames", frames_fwd, 16'd0);
        s0_vsync = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        blank_chk("post_rst_hold");
        chk("post_rst_frames", frames_fwd, 16'd0);
        s0_vsync = 1'b0;
        tick();
        s0_vsync = 1'b1; s0_data = 8'h42;
        tick();
        chk("post_rst_sof", {gnt, out_vsync, out_data}, {2'b01, 1'b1, 8'h42});
        chk("post_rst_frames2", frames_fwd, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/doubler_frame_arbiter.md
# doubler_frame_arbiter

Frame-granular arbiter that shares one `bus_doubler` between two parallel video sources (hsync/vsync/den/data). It sits directly upstream of `bus_doubler` in the `in_clk` domain, selects one source at a time, and forwards its registered video signals. Ownership changes only at frame boundaries, so the doubler never sees a torn frame; the output is blanked while waiting for the next owner's start of frame.

## Interface
- `INPUT_WIDTH`, 8, pixel data width per source; equals `bus_doubler` input width.
- `FRAME_QUOTA`, 2, frames a source may hold the bus while the other requests; range 1..255.

- `in_clk`  input  1  pixel clock shared by both sources and the doubler.
- `rst`  input  1  asynchronous, active-high reset.
- `s0_req`, `s1_req`  input  1 each  source requests ownership; level-sensitive.
- `s0_hsync`, `s0_vsync`, `s0_den`  input  1 each  source 0 video controls.
- `s0_data`  input  INPUT_WIDTH  source 0 pixel.
- `s1_hsync`, `s1_vsync`, `s1_den`  input  1 each  source 1 video controls.
- `s1_data`  input  INPUT_WIDTH  source 1 pixel.
- `out_hsync`, `out_vsync`, `out_den`  output  1 each  to `bus_doubler` `in_*`.
- `out_data`  output  INPUT_WIDTH  to `bus_doubler` `in_data`.
- `gnt`  output  2  one-hot owner while streaming; 00 otherwise.
- `frames_fwd`  output  16  total frames forwarded, wraps at 0xFFFF->0.

## Operation
- SOF(x): `sx_vsync`=1 this cycle and was 0 last cycle. Per-source vsync history registers always sample and reset to 0.
- Blank: out_hsync=out_vsync=out_den=0, out_data=0.
- Round-robin pointer `rr` (reset 0) names the preferred source when both request.
- States:
  - IDLE: output blank. If a request is present, set cand = `rr` if that source requests, else the other one; go to WAIT_SOF.
  - WAIT_SOF: output blank. If `cand` req=0, go to IDLE. Else on SOF(cand): go to STREAM with owner=cand, quota_cnt=1, `rr`=other, frames_fwd+1, and forward this cycle.
  - STREAM: forward the owner's signals each cycle. On SOF(owner):
    - If owner req=0: blank this cycle. Go to WAIT_SOF(other) if the other requests, else IDLE.
    - Else if quota_cnt==FRAME_QUOTA and the other requests: blank, go to WAIT_SOF(other).
    - Else: forward, quota_cnt = min(quota_cnt+1, FRAME_QUOTA), frames_fwd+1.
- Owner req dropping mid-frame has no effect until the next SOF(owner). The current frame always completes.
- Non-owner inputs are ignored entirely, including its SOF.
- With only one requester, ownership never times out. quota_cnt saturates.
- If both SOFs fire in the same cycle, only the owner's (STREAM) or the cand's (WAIT_SOF) is evaluated.

## Timing
- All outputs are registered. Forwarded signals appear 1 cycle after the source input sample.
- A blanked cycle loads blank into the output registers on that edge.
- `gnt` updates on the same edge that first forwards the SOF cycle. It clears on the edge that loads the first blank.
- Reset values: all out_* = 0, gnt=00, frames_fwd=0, state IDLE, rr=0, quota_cnt=0.
- Reset asserted mid-frame: outputs go blank asynchronously. After release, the block waits for a fresh SOF.
- Minimum switch gap: 1 blank cycle plus the time until the new source's SOF.

## Test plan
- Reset: hold rst=1 with both sources toggling -> all outputs 0, gnt=00. Release; no req -> outputs stay blank indefinitely.
- Single source: s0_req=1, s0 drives vsync rise then den=1 with data 0xA1, 0x53 -> out_vsync=1 one cycle after SOF, gnt=01. out_data shows 0xA1, 0x53 each delayed one cycle. frames_fwd=1.
- Fairness, FRAME_QUOTA=2, both req=1 from reset:
  - s0 granted first and forwards 2 frames.
  - The 3rd SOF(s0) is blanked; gnt=00 until SOF(s1), then gnt=10.
  - After 2 s1 frames, control returns to s0. frames_fwd counts 4 after the first full rotation.
- Mid-frame drop: s0 streaming, s0_req falls while den=1 -> the frame continues to forward until the next SOF(s0). That cycle is blanked and the block goes to IDLE with gnt=00.
- Cand withdraws: s1_req pulses 1 in IDLE then drops before any SOF(s1) -> WAIT_SOF returns to IDLE. gnt never asserts and frames_fwd is unchanged.
- Reset mid-stream: assert rst while out_den=1 -> out_den=0 immediately. After release, no forwarding occurs until a new SOF, even if vsync is already high.
